// File: rtl/dcsk_mod_tx.sv
// dcsk_mod_tx: DCSK modulator emitting a chaotic reference segment then its copy (bit=1) or inverse (bit=0) per information bit
//   Clk, N_Rst         : clock, asynchronous active-low reset
//   In_Data/In_Valid   : 32-bit word, sent MSB first; In_Ready high when idle
//   Spread_Factor_Sel  : 00->4, 01->8, 1x->16 chips per segment, latched on accept
//   Mod_Data/Mod_Valid : registered chip stream; Frame_Done pulses with the last chip
module dcsk_mod_tx #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        N_Rst,
  input  logic [31:0] In_Data,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [1:0]  Spread_Factor_Sel,
  output logic        Mod_Data,
  output logic        Mod_Valid,
  output logic        Frame_Done
);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  typedef enum logic [1:0] {IDLE, REF, INFO} state_t;
  // state/cnt/bidx describe the chip currently on Mod_Data; the n* values
  // describe the chip loaded at the next edge, so outputs stay registered
  // while the first chip still appears right after the accepting edge.
  state_t      state, nstate;
  logic [3:0]  cnt, ncnt, sf_m1;
  logic [4:0]  bidx, nbidx;
  logic [31:0] word;
  logic [15:0] lfsr, ref_buf;
  logic        seg_end, fb;
  assign In_Ready = state == IDLE;
  assign seg_end  = cnt == sf_m1;
  assign fb       = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  always_comb begin
    nstate = state;
    ncnt   = 4'd0;
    nbidx  = bidx;
    case (state)
      IDLE: begin
        nbidx = 5'd31;
        if (In_Valid) nstate = REF;
      end
      REF: begin
        if (seg_end) nstate = INFO;
        else ncnt = cnt + 4'd1;
      end
      INFO: begin
        if (!seg_end) ncnt = cnt + 4'd1;
        else if (bidx == 5'd0) nstate = IDLE;
        else begin
          nstate = REF;
          nbidx  = bidx - 5'd1;
        end
      end
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge N_Rst) begin
    if (!N_Rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      bidx       <= 5'd31;
      sf_m1      <= 4'd3;
      word       <= 32'd0;
      lfsr       <= SEED_EFF;
      ref_buf    <= 16'd0;
      Mod_Data   <= 1'b0;
      Mod_Valid  <= 1'b0;
      Frame_Done <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      bidx  <= nbidx;
      if (In_Ready && In_Valid) begin
        word  <= In_Data;
        sf_m1 <= Spread_Factor_Sel == 2'b00 ? 4'd3 : Spread_Factor_Sel == 2'b01 ? 4'd7 : 4'd15;
      end
      if (nstate == REF) begin
        ref_buf[ncnt] <= lfsr[15];
        lfsr          <= {lfsr[14:0], fb};
      end
      Mod_Valid  <= nstate != IDLE;
      Mod_Data   <= nstate == REF ? lfsr[15] : (nstate == INFO) && (ref_buf[ncnt] ^ ~word[nbidx]);
      Frame_Done <= nstate == INFO && ncnt == sf_m1 && nbidx == 5'd0;
    end
  end
endmodule
